io_buff_arbiter: RTL and testbench

- Shares one input buffer and one output buffer between NREQ requesters (CPU core, debug port, ...).
- Round-robin arbitration between requesters.
- Generates the level readdone/writedone strobes the buffers edge-detect, with the required low gap between strobes so every strobe is seen.
- Owns the clkdiv configuration register that feeds both buffers.

---
 rtl/io_buff_pkg.sv | 21 ++
 rtl/io_buff_arbiter_rr_arbiter.sv | 32 +++
 rtl/io_buff_arbiter.sv | 149 ++++++++++++++
 tb/tb_io_buff_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/io_buff_pkg.sv
// Shared types and constants for the I/O buffer arbiter.
package io_buff_pkg;

  // Transaction FSM states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_STROBE  = 3'd1,
    RD_CAPTURE = 3'd2,
    WR_SETUP   = 3'd3,
    WR_STROBE  = 3'd4,
    RELEASE    = 3'd5,
    DONE       = 3'd6
  } state_t;

  // Default data width.
  localparam int W_DEF = 16;

  // Width of the post-strobe low-gap counter; GAP is limited to 1..7.
  localparam int GAP_W = 3;

endpackage

// File: rtl/io_buff_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first active request above ptr
// (wrapping modulo NREQ) wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  // Walk offsets 1..NREQ from the pointer; the last one is ptr itself, so
  // a lone requester that just won can win again.
  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/io_buff_arbiter.sv
// Arbitrates NREQ requesters onto one input buffer and one output buffer,
// generating gapped level strobes and owning the shared clkdiv register.
module io_buff_arbiter
  import io_buff_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = W_DEF,
  parameter int GAP     = 1,
  parameter int DIV_RST = 50
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_rd,
  input  logic [NREQ-1:0] req_wr,
  input  logic [NREQ*W-1:0] req_wdata,
  output logic [NREQ-1:0] ack,
  output logic            nak,
  output logic [W-1:0]    rdata,
  input  logic [W-1:0]    ib_data,
  input  logic            ib_toread,
  output logic            ib_readdone,
  output logic [W-1:0]    ob_data,
  input  logic            ob_towrite,
  output logic            ob_writedone,
  input  logic            cfg_we,
  input  logic [W-1:0]    cfg_div,
  output logic [W-1:0]    clkdiv
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_reg, state_next;
  logic [IW-1:0]     ptr_reg;
  logic [IW-1:0]     gidx_reg;
  logic              nak_reg;
  logic [W-1:0]      rdata_reg;
  logic [W-1:0]      ob_data_reg;
  logic [GAP_W-1:0]  cnt_reg;
  logic [W-1:0]      clkdiv_reg;

  logic [NREQ-1:0]   active;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     idx;
  logic              any;
  logic              rd_sel;
  logic              refuse;
  logic              done;

  assign active = req_rd | req_wr;
  assign any    = |grant;
  // Read wins when a requester raises both.
  assign rd_sel = req_rd[idx];
  assign refuse = rd_sel ? !ib_toread : !ob_towrite;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (active),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (idx)
  );

  // State register, grant latches, captured read data and gap counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= IW'(NREQ - 1);
      gidx_reg    <= '0;
      nak_reg     <= 1'b0;
      rdata_reg   <= '0;
      ob_data_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any) begin
        ptr_reg  <= idx;
        gidx_reg <= idx;
        nak_reg  <= refuse;
        if (!rd_sel && !refuse) begin
          ob_data_reg <= req_wdata[int'(idx)*W +: W];
        end
      end
      if (state_reg == RD_CAPTURE) begin
        rdata_reg <= ib_data;
      end
      if (state_reg == RELEASE) begin
        cnt_reg <= cnt_reg + GAP_W'(1);
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  // Divider configuration register, writable in any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clkdiv_reg <= W'(DIV_RST);
    end else if (cfg_we) begin
      clkdiv_reg <= cfg_div;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_next   = state_reg;
    ib_readdone  = 1'b0;
    ob_writedone = 1'b0;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any) begin
          if (refuse)      state_next = DONE;
          else if (rd_sel) state_next = RD_STROBE;
          else             state_next = WR_SETUP;
        end
      end
      RD_STROBE: begin
        ib_readdone = 1'b1;
        state_next  = RD_CAPTURE;
      end
      RD_CAPTURE: state_next = RELEASE;
      WR_SETUP:   state_next = WR_STROBE;
      WR_STROBE: begin
        ob_writedone = 1'b1;
        state_next   = RELEASE;
      end
      RELEASE: begin
        if (cnt_reg == GAP_W'(GAP - 1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One-hot completion pulse for the latched grant.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
      assign ack[gi] = done && (gidx_reg == IW'(gi));
    end
  endgenerate

  assign nak     = done && nak_reg;
  assign rdata   = rdata_reg;
  assign ob_data = ob_data_reg;
  assign clkdiv  = clkdiv_reg;

endmodule

// File: tb/tb_io_buff_arbiter.sv
// Self-checking bench for io_buff_arbiter: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_io_buff_arbiter;

  localparam int NREQ    = 2;
  localparam int W       = 16;
  localparam int GAP     = 1;
  localparam int DIV_RST = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_rd, req_wr;
  logic [NREQ*W-1:0] req_wdata;
  logic [NREQ-1:0]   ack;
  logic              nak;
  logic [W-1:0]      rdata;
  logic [W-1:0]      ib_data;
  logic              ib_toread;
  logic              ib_readdone;
  logic [W-1:0]      ob_data;
  logic              ob_towrite;
  logic              ob_writedone;
  logic              cfg_we;
  logic [W-1:0]      cfg_div;
  logic [W-1:0]      clkdiv;

  io_buff_arbiter #(.NREQ(NREQ), .W(W), .GAP(GAP), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_wdata(req_wdata), .ack(ack), .nak(nak), .rdata(rdata),
    .ib_data(ib_data), .ib_toread(ib_toread), .ib_readdone(ib_readdone),
    .ob_data(ob_data), .ob_towrite(ob_towrite), .ob_writedone(ob_writedone),
    .cfg_we(cfg_we), .cfg_div(cfg_div), .clkdiv(clkdiv)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int         ptr_m;
  logic [W-1:0] rdata_m, obdata_m, clk_m;
  int         since_strobe;
  bit         rand_cfg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Round-robin choice from the rule: first active index after ptr, wrapping.
  function automatic int pick(input int ptr, input logic [NREQ-1:0] act);
    for (int k = 1; k <= NREQ; k++) begin
      if (act[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Advance one clock; update config model and check clkdiv and strobe gaps.
  task automatic step();
    logic         r_s, we_s;
    logic [W-1:0] div_s;
    r_s = rst_n; we_s = cfg_we; div_s = cfg_div;
    @(posedge clk);
    if (!r_s)      clk_m = W'(DIV_RST);
    else if (we_s) clk_m = div_s;
    #1;
    chk("clkdiv", 32'(clkdiv), 32'(clk_m));
    if (ib_readdone || ob_writedone) begin
      if (since_strobe >= 0) chk("strobe_gap_ok", 32'(since_strobe >= GAP + 1), 32'd1);
      since_strobe = 0;
    end else if (since_strobe >= 0) begin
      since_strobe++;
    end
    if (!r_s) since_strobe = -1;
    if (rand_cfg) begin
      cfg_we  = ($urandom_range(0, 3) == 0);
      cfg_div = W'($urandom);
    end
  endtask

  // Run one transaction starting in an IDLE cycle, checking every cycle up
  // to the ack and the IDLE cycle after it.
  task automatic run_txn(input logic [NREQ-1:0] rd, input logic [NREQ-1:0] wr,
                         input logic [NREQ*W-1:0] wd, input logic tr, input logic tw,
                         input logic [W-1:0] ibd);
    int   g, len;
    logic is_rd, ok;
    req_rd = rd; req_wr = wr; req_wdata = wd;
    ib_toread = tr; ob_towrite = tw; ib_data = ibd;
    g     = pick(ptr_m, rd | wr);
    is_rd = rd[g];
    ok    = is_rd ? tr : tw;
    len   = ok ? 3 + GAP : 1;
    ptr_m = g;
    for (int k = 1; k <= len; k++) begin
      step();
      if (k == 1 && !is_rd && ok) obdata_m = wd[g*W +: W];
      if (k == 3 && is_rd && ok)  rdata_m  = ibd;
      chk("ib_readdone",  32'(ib_readdone),  32'(is_rd && ok && k == 1));
      chk("ob_writedone", 32'(ob_writedone), 32'(!is_rd && ok && k == 2));
      chk("ack",  32'(ack), (k == len) ? (32'd1 << g) : 32'd0);
      chk("nak",  32'(nak), 32'((k == len) && !ok));
      chk("rdata",   32'(rdata),   32'(rdata_m));
      chk("ob_data", 32'(ob_data), 32'(obdata_m));
      if (k < len) begin
        // Busy-phase input noise must be ignored.
        req_rd = NREQ'($urandom); req_wr = NREQ'($urandom);
        req_wdata = {$urandom, $urandom};
        ib_toread = 1'($urandom); ob_towrite = 1'($urandom);
      end else begin
        req_rd = '0; req_wr = '0;
      end
    end
    step();
    chk("idle_ack", 32'(ack), 32'd0);
    chk("idle_strobes", 32'({ib_readdone, ob_writedone}), 32'd0);
    $display("txn req=%0d op=%s ok=%0d ack=%0d rdata=%h ob_data=%h", g,
             is_rd ? "rd" : "wr", ok, len, rdata, ob_data);
  endtask

  initial begin
    logic [NREQ-1:0] rd, wr;
    rand_cfg = 0; since_strobe = -1;
    rst_n = 0; req_rd = '0; req_wr = '0; req_wdata = '0; ib_data = '0;
    ib_toread = 0; ob_towrite = 0; cfg_we = 0; cfg_div = '0;
    clk_m = '0; rdata_m = '0; obdata_m = '0; ptr_m = NREQ - 1;

    // Reset state.
    step(); step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_nak", 32'(nak), 32'd0);
    chk("rst_strobes", 32'({ib_readdone, ob_writedone}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ob_data", 32'(ob_data), 32'd0);
    chk("rst_clkdiv", 32'(clkdiv), 32'd50);
    rst_n = 1; cfg_we = 1; cfg_div = 16'd7;
    step();
    chk("cfg_clkdiv", 32'(clkdiv), 32'd7);
    cfg_we = 0;
    step();

    // Directed transactions.
    run_txn(2'b01, 2'b00, '0, 1'b1, 1'b0, 16'hBEEF);
    run_txn(2'b01, 2'b00, '0, 1'b0, 1'b0, 16'h5555);
    run_txn(2'b00, 2'b10, {16'h1234, 16'hAAAA}, 1'b0, 1'b1, 16'h0);

    // Reset while in RD_CAPTURE.
    req_rd = 2'b01; ib_toread = 1; ib_data = 16'hCAFE;
    step(); step();
    rst_n = 0; req_rd = '0;
    step();
    rdata_m = '0; obdata_m = '0; ptr_m = NREQ - 1;
    chk("mid_rst_readdone", 32'(ib_readdone), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1;
    step();
    chk("post_rst_ack", 32'(ack), 32'd0);
    $display("txn reset during RD_CAPTURE");

    // Both requesters reading continuously: grants alternate 0,1,0,1.
    for (int n = 0; n < 4; n++) begin
      chk("alt_grant", 32'(pick(ptr_m, 2'b11)), 32'(n % 2));
      run_txn(2'b11, 2'b00, '0, 1'b1, 1'b1, W'(16'h1000 + n));
    end

    // Randomized transactions with random config writes.
    rand_cfg = 1;
    for (int n = 0; n < 40; n++) begin
      do begin
        rd = NREQ'($urandom); wr = NREQ'($urandom);
      end while ((rd | wr) == '0);
      run_txn(rd, wr, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 3) != 0), W'($urandom));
    end
    rand_cfg = 0; cfg_we = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
